coin_front_end: RTL and testbench



---
 rtl/coin_front_end_if.sv | 26 ++
 rtl/coin_front_end.sv | 253 +++++++++++++++++++++++++
 tb/tb_coin_front_end.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_front_end_if.sv
// Coin front-end bus: raw sensor lines in, conditioned coin codes and queue status out.
interface coin_front_end_if;
  logic       coin1_raw;
  logic       coin2_raw;
  logic [1:0] coin_code;
  logic       fifo_full;
  logic       drop;

  // Sensor/consumer side
  modport master (
    output coin1_raw,
    output coin2_raw,
    input  coin_code,
    input  fifo_full,
    input  drop
  );

  // Front-end side
  modport slave (
    input  coin1_raw,
    input  coin2_raw,
    output coin_code,
    output fifo_full,
    output drop
  );
endinterface

// File: rtl/coin_front_end.sv
// Coin sensor front end: synchronize, debounce and edge-detect two coin lines, queue the
// detected coins and drain them as single-cycle codes separated by a programmable idle gap.
module coin_front_end #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  coin_front_end_if.slave  bus
);

  localparam int unsigned CntW    = $clog2(DEB_CYCLES + 1);
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW    = PtrW + 1;
  localparam int unsigned RoomW   = OccW + 1;
  localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GapLoad = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CntW-1:0] DebLast  = CntW'(DEB_CYCLES - 1);
  localparam logic [OccW-1:0] DepthOcc = OccW'(FIFO_DEPTH);
  localparam logic [GapW-1:0] GapInit  = GapW'(GapLoad);

  localparam logic [1:0] CodeNone = 2'd0;
  localparam logic [1:0] CodeOne  = 2'd1;
  localparam logic [1:0] CodeTwo  = 2'd2;

  // ---------------------------------------------------------------------------------------------
  // Input conditioning (bit 0 = 1-unit line, bit 1 = 2-unit line)
  // ---------------------------------------------------------------------------------------------
  logic [1:0]      raw;
  logic [1:0]      meta_q;
  logic [1:0]      sync_q;
  logic [1:0]      filt_q;
  logic [1:0]      filt_d;
  logic [1:0]      filt_dly_q;
  logic [CntW-1:0] deb_cnt_q [2];
  logic [CntW-1:0] deb_cnt_d [2];
  logic [1:0]      ev;

  assign raw = {bus.coin2_raw, bus.coin1_raw};

  // Two-flop synchronizer on each raw sensor line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // Debounce: a new level is accepted only after DEB_CYCLES consecutive differing samples
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i]    = filt_q[i];
      deb_cnt_d[i] = deb_cnt_q[i];
      if (sync_q[i] == filt_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DebLast) begin
        filt_d[i]    = sync_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + CntW'(1);
      end
    end
  end

  // Filtered levels, their delayed copies and the debounce counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q       <= '0;
      filt_dly_q   <= '0;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
    end else begin
      filt_q       <= filt_d;
      filt_dly_q   <= filt_q;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
    end
  end

  // Coin arrival is the rising edge of the filtered level; coin exit is ignored
  assign ev = filt_q & ~filt_dly_q;

  // ---------------------------------------------------------------------------------------------
  // Coin queue
  // ---------------------------------------------------------------------------------------------
  logic [1:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wptr_q;
  logic [PtrW-1:0]  wptr_d;
  logic [PtrW-1:0]  rptr_q;
  logic [PtrW-1:0]  rptr_d;
  logic [OccW-1:0]  occ_q;
  logic [OccW-1:0]  occ_d;
  logic [RoomW-1:0] room;
  logic [1:0]       n_push;
  logic [1:0]       push_code;
  logic             full_q;
  logic             drop_q;
  logic             drop_d;
  logic             pop;
  logic             empty;
  logic [1:0]       head;

  assign empty = (occ_q == '0);
  assign head  = mem_q[rptr_q];

  // Push arbitration: a same-cycle pop frees a slot; with both coins the 1-unit one goes first
  always_comb begin
    room      = RoomW'(FIFO_DEPTH) - RoomW'(occ_q) + RoomW'(pop);
    n_push    = 2'd0;
    push_code = CodeOne;
    drop_d    = 1'b0;
    case (ev)
      2'b11: begin
        if (room >= RoomW'(2)) begin
          n_push = 2'd2;
        end else if (room == RoomW'(1)) begin
          n_push = 2'd1;
          drop_d = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end
      2'b01: begin
        push_code = CodeOne;
        if (room != '0) n_push = 2'd1;
        else            drop_d = 1'b1;
      end
      2'b10: begin
        push_code = CodeTwo;
        if (room != '0) n_push = 2'd1;
        else            drop_d = 1'b1;
      end
      default: ;
    endcase
    occ_d  = occ_q + OccW'(n_push) - OccW'(pop);
    wptr_d = wptr_q + PtrW'(n_push);
    rptr_d = rptr_q + PtrW'(pop);
  end

  // Queue storage: up to two entries written per cycle, second one always the 2-unit code
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) mem_q[wptr_q] <= push_code;
    if (n_push == 2'd2) mem_q[wptr_q + PtrW'(1)] <= CodeTwo;
  end

  // Queue pointers, occupancy and the registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      full_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      full_q <= (occ_d == DepthOcc);
      drop_q <= drop_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Emitter
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [1:0] {StIdle, StEmit, StGap} state_e;

  state_e          state_q;
  state_e          state_d;
  logic [GapW-1:0] gap_q;
  logic [GapW-1:0] gap_d;
  logic [1:0]      code_q;
  logic [1:0]      code_d;

  // Emitter state, gap counter and registered coin code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gap_q   <= '0;
      code_q  <= CodeNone;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      code_q  <= code_d;
    end
  end

  // Emitter next state; the last gap cycle doubles as an idle check so spacing is 1+GAP_CYCLES
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) state_d = StEmit;
      end
      StEmit: begin
        if (GAP_CYCLES > 0) begin
          state_d = StGap;
          gap_d   = GapInit;
        end else if (!empty) begin
          state_d = StEmit;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = empty ? StIdle : StEmit;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Emitter outputs: pop the head and load it as the next code whenever a slot opens
  always_comb begin
    pop    = 1'b0;
    code_d = CodeNone;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop    = 1'b1;
          code_d = head;
        end
      end
      StEmit: begin
        if ((GAP_CYCLES == 0) && !empty) begin
          pop    = 1'b1;
          code_d = head;
        end
      end
      StGap: begin
        if ((gap_q == '0) && !empty) begin
          pop    = 1'b1;
          code_d = head;
        end
      end
      default: ;
    endcase
  end

  assign bus.coin_code = code_q;
  assign bus.fifo_full = full_q;
  assign bus.drop      = drop_q;

endmodule

// File: tb/tb_coin_front_end.sv
// Directed bench for coin_front_end: three parameterizations driven from one clock.
//   dut 0: DEB=16 DEPTH=4 GAP=1   dut 1: DEB=2 DEPTH=4 GAP=8   dut 2: DEB=2 DEPTH=4 GAP=0
module tb_coin_front_end;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  coin_front_end_if if_a ();
  coin_front_end_if if_b ();
  coin_front_end_if if_c ();

  coin_front_end #(.DEB_CYCLES(16), .FIFO_DEPTH(4), .GAP_CYCLES(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  coin_front_end #(.DEB_CYCLES(2), .FIFO_DEPTH(4), .GAP_CYCLES(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  coin_front_end #(.DEB_CYCLES(2), .FIFO_DEPTH(4), .GAP_CYCLES(0)) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (if_c.slave)
  );

  typedef struct {
    int   sel;
    logic c1;
    logic c2;
    int   hold;
    int   exp_n;
    int   exp_lat1;
    int   exp_code1;
    int   exp_lat2;
    int   exp_code2;
  } vec_t;

  vec_t vecs [10];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int n_three;
  int n_codes  [3];
  int lat1     [3];
  int code1    [3];
  int lat2     [3];
  int code2    [3];
  int n_drop   [3];
  int saw_full [3];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] get_code(input int s);
    case (s)
      0:       get_code = if_a.coin_code;
      1:       get_code = if_b.coin_code;
      default: get_code = if_c.coin_code;
    endcase
  endfunction

  function automatic logic get_full(input int s);
    case (s)
      0:       get_full = if_a.fifo_full;
      1:       get_full = if_b.fifo_full;
      default: get_full = if_c.fifo_full;
    endcase
  endfunction

  function automatic logic get_drop(input int s);
    case (s)
      0:       get_drop = if_a.drop;
      1:       get_drop = if_b.drop;
      default: get_drop = if_c.drop;
    endcase
  endfunction

  task automatic set_raw(input int s, input logic c1, input logic c2);
    case (s)
      0: begin if_a.coin1_raw = c1; if_a.coin2_raw = c2; end
      1: begin if_b.coin1_raw = c1; if_b.coin2_raw = c2; end
      default: begin if_c.coin1_raw = c1; if_c.coin2_raw = c2; end
    endcase
  endtask

  task automatic clear_stats();
    cyc = 0;
    for (int s = 0; s < 3; s++) begin
      n_codes[s]  = 0;
      lat1[s]     = 0;
      code1[s]    = 0;
      lat2[s]     = 0;
      code2[s]    = 0;
      n_drop[s]   = 0;
      saw_full[s] = 0;
    end
  endtask

  // Advance one clock and sample every DUT 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int s = 0; s < 3; s++) begin
      logic [1:0] c;
      c = get_code(s);
      if (c == 2'd3) n_three++;
      if (c != 2'd0) begin
        n_codes[s]++;
        if (lat1[s] == 0) begin
          lat1[s]  = cyc;
          code1[s] = int'(c);
        end else if (lat2[s] == 0) begin
          lat2[s]  = cyc;
          code2[s] = int'(c);
        end
      end
      if (get_drop(s)) n_drop[s]++;
      if (get_full(s)) saw_full[s] = 1;
    end
  endtask

  task automatic do_reset();
    for (int s = 0; s < 3; s++) set_raw(s, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_three = 0;
    for (int s = 0; s < 3; s++) set_raw(s, 1'b0, 1'b0);
    rst = 1'b1;
    clear_stats();

    //          sel c1    c2    hold n  lat1 c1 lat2 c2
    vecs[0] = '{0, 1'b1, 1'b0, 40,  1, 20,  1, 0,   0};  // clean 1-unit coin
    vecs[1] = '{0, 1'b0, 1'b1, 40,  1, 20,  2, 0,   0};  // clean 2-unit coin
    vecs[2] = '{0, 1'b1, 1'b1, 40,  2, 20,  1, 22,  2};  // simultaneous: 1, 0, 2
    vecs[3] = '{0, 1'b1, 1'b0, 15,  0, 0,   0, 0,   0};  // one sample short: rejected
    vecs[4] = '{0, 1'b0, 1'b1, 16,  1, 20,  2, 0,   0};  // exactly DEB samples: accepted
    vecs[5] = '{2, 1'b1, 1'b0, 10,  1, 6,   1, 0,   0};  // DEB=2 latency
    vecs[6] = '{2, 1'b1, 1'b1, 10,  2, 6,   1, 7,   2};  // GAP=0 back-to-back
    vecs[7] = '{2, 1'b0, 1'b1, 1,   0, 0,   0, 0,   0};  // single-sample glitch
    vecs[8] = '{2, 1'b0, 1'b1, 2,   1, 6,   2, 0,   0};  // minimum accepted pulse
    vecs[9] = '{1, 1'b1, 1'b1, 10,  2, 6,   1, 15,  2};  // GAP=8 spacing of 9

    // Asynchronous reset values, before any clock edge
    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_code_dut%0d", s), int'(get_code(s)), 0);
      check($sformatf("reset_full_dut%0d", s), int'(get_full(s)), 0);
      check($sformatf("reset_drop_dut%0d", s), int'(get_drop(s)), 0);
    end

    for (int v = 0; v < 10; v++) begin
      do_reset();
      set_raw(vecs[v].sel, vecs[v].c1, vecs[v].c2);
      clear_stats();
      for (int i = 0; i < 64; i++) begin
        if (i == vecs[v].hold) set_raw(vecs[v].sel, 1'b0, 1'b0);
        tick();
      end
      check($sformatf("vec%0d_count", v), n_codes[vecs[v].sel], vecs[v].exp_n);
      check($sformatf("vec%0d_lat1", v),  lat1[vecs[v].sel],    vecs[v].exp_lat1);
      check($sformatf("vec%0d_code1", v), code1[vecs[v].sel],   vecs[v].exp_code1);
      check($sformatf("vec%0d_lat2", v),  lat2[vecs[v].sel],    vecs[v].exp_lat2);
      check($sformatf("vec%0d_code2", v), code2[vecs[v].sel],   vecs[v].exp_code2);
      check($sformatf("vec%0d_drops", v), n_drop[vecs[v].sel],  0);
    end

    // Bounce rejection: 5/3/10-cycle pulses never qualify; the 30-cycle high starts at edge 31
    begin
      int lvl [7];
      int len [7];
      lvl = '{1, 0, 1, 0, 1, 0, 1};
      len = '{5, 4, 3, 4, 10, 4, 30};
      do_reset();
      clear_stats();
      for (int k = 0; k < 7; k++) begin
        set_raw(0, 1'b0, lvl[k] != 0);
        for (int j = 0; j < len[k]; j++) tick();
      end
      set_raw(0, 1'b0, 1'b0);
      for (int j = 0; j < 40; j++) tick();
      check("bounce_count", n_codes[0], 1);
      check("bounce_code",  code1[0],   2);
      check("bounce_lat",   lat1[0],    50);
      check("bounce_drops", n_drop[0],  0);
    end

    // Overflow: ten 1-unit coins every 4 cycles against a 9-cycle drain; last two are dropped
    do_reset();
    clear_stats();
    for (int k = 0; k < 10; k++) begin
      set_raw(1, 1'b1, 1'b0);
      tick();
      tick();
      set_raw(1, 1'b0, 1'b0);
      tick();
      tick();
    end
    for (int j = 0; j < 80; j++) tick();
    check("ovf_emitted", n_codes[1], 8);
    check("ovf_drops",   n_drop[1],  2);
    check("ovf_full",    saw_full[1], 1);
    check("ovf_total",   n_codes[1] + n_drop[1], 10);
    check("ovf_code",    code1[1],   1);

    // Reset mid-operation: three coins queued in dut 1 when reset hits
    do_reset();
    clear_stats();
    set_raw(1, 1'b1, 1'b1);
    tick();
    tick();
    set_raw(1, 1'b0, 1'b0);
    tick();
    tick();
    set_raw(1, 1'b1, 1'b1);
    tick();
    tick();
    set_raw(1, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) tick();
    check("midrst_pre_emitted", n_codes[1], 1);
    rst = 1'b1;
    #1;
    check("midrst_async_code", int'(get_code(1)), 0);
    check("midrst_async_full", int'(get_full(1)), 0);
    tick();
    tick();
    rst = 1'b0;
    clear_stats();
    for (int j = 0; j < 40; j++) tick();
    check("midrst_post_codes", n_codes[1],  0);
    check("midrst_post_full",  saw_full[1], 0);
    check("midrst_post_drops", n_drop[1],   0);
    set_raw(1, 1'b1, 1'b0);
    clear_stats();
    for (int j = 0; j < 30; j++) begin
      if (j == 6) set_raw(1, 1'b0, 1'b0);
      tick();
    end
    check("midrst_fresh_count", n_codes[1], 1);
    check("midrst_fresh_lat",   lat1[1],    6);
    check("midrst_fresh_code",  code1[1],   1);

    check("never_code3", n_three, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
